// File: rtl/tdm_demux_1x8_nbit.sv
// ============================================================================
// Module   : tdm_demux_1x8_nbit
// Purpose  : 1-to-8 time-division demultiplexer. Collects an 8-word frame
//            (framed by sof) into shadow registers and publishes all eight
//            slots at once on frame completion.
// Option   : TDM_DEMUX_ERR_EN adds the err framing-error pulse output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux_1x8_nbit #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    input  logic         valid,
    input  logic         sof,
    output logic [N-1:0] q0,
    output logic [N-1:0] q1,
    output logic [N-1:0] q2,
    output logic [N-1:0] q3,
    output logic [N-1:0] q4,
    output logic [N-1:0] q5,
    output logic [N-1:0] q6,
    output logic [N-1:0] q7,
    output logic         frame_done,
    output logic [2:0]   slot
`ifdef TDM_DEMUX_ERR_EN
    ,
    output logic         err
`endif
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          slot_q, slot_d;
    logic [6:0][N-1:0]   sh_q, sh_d;
    logic [7:0][N-1:0]   q_q, q_d;
    logic                frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        sh_d         = sh_q;
        q_d          = q_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Words without sof are strays and are dropped here.
                if (valid && sof) begin
                    sh_d[0] = din;
                    slot_d  = 3'd1;
                    state_d = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (valid) begin
                    if (sof) begin
                        // Restart: the partial frame is abandoned, q untouched.
                        sh_d[0] = din;
                        slot_d  = 3'd1;
                    end else if (slot_q == 3'd7) begin
                        q_d[6:0]     = sh_q;
                        q_d[7]       = din;
                        frame_done_d = 1'b1;
                        slot_d       = 3'd0;
                        state_d      = S_IDLE;
                    end else begin
                        for (int i = 1; i < 7; i++) begin
                            if (slot_q == 3'(i)) begin
                                sh_d[i] = din;
                            end
                        end
                        slot_d = slot_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            slot_q       <= 3'd0;
            sh_q         <= '0;
            q_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            sh_q         <= sh_d;
            q_q          <= q_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef TDM_DEMUX_ERR_EN
    logic err_q, err_d;

    // Short frame (sof while collecting) or stray word (no sof while idle).
    always_comb begin
        err_d = 1'b0;
        if (valid) begin
            err_d = sof ? (state_q == S_COLLECT) : (state_q == S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign q0         = q_q[0];
    assign q1         = q_q[1];
    assign q2         = q_q[2];
    assign q3         = q_q[3];
    assign q4         = q_q[4];
    assign q5         = q_q[5];
    assign q6         = q_q[6];
    assign q7         = q_q[7];
    assign frame_done = frame_done_q;
    assign slot       = slot_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_1x8_nbit.sv
// ============================================================================
// Module   : tb_tdm_demux_1x8_nbit
// Purpose  : Directed self-checking bench for tdm_demux_1x8_nbit with a
//            frame-queue reference model (TDM_DEMUX_ERR_EN adds err checks).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_1x8_nbit;

    localparam int N = 3;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] din   = '0;
    logic         valid = 1'b0;
    logic         sof   = 1'b0;
    logic [N-1:0] dq [8];
    logic         frame_done;
    logic [2:0]   slot;
`ifdef TDM_DEMUX_ERR_EN
    logic         err;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: words of the frame in progress plus expected outputs.
    logic [N-1:0] fr [$];
    logic [N-1:0] exp_q [8] = '{default: '0};
    logic         exp_fd   = 1'b0;
    int           exp_slot = 0;
    logic         exp_err  = 1'b0;

    tdm_demux_1x8_nbit #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .valid      (valid),
        .sof        (sof),
        .q0         (dq[0]),
        .q1         (dq[1]),
        .q2         (dq[2]),
        .q3         (dq[3]),
        .q4         (dq[4]),
        .q5         (dq[5]),
        .q6         (dq[6]),
        .q7         (dq[7]),
        .frame_done (frame_done),
        .slot       (slot)
`ifdef TDM_DEMUX_ERR_EN
        ,
        .err        (err)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        n_total++;
        if (act !== expv) begin
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: a frame is the run of accepted words starting at sof; it publishes at 8 words.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            fr.delete();
            exp_q    = '{default: '0};
            exp_fd   = 1'b0;
            exp_slot = 0;
            exp_err  = 1'b0;
        end else begin
            exp_fd  = 1'b0;
            exp_err = 1'b0;
            if (valid) begin
                if (sof) begin
                    if (fr.size() > 0) exp_err = 1'b1;
                    fr.delete();
                    fr.push_back(din);
                end else if (fr.size() == 0) begin
                    exp_err = 1'b1;
                end else begin
                    fr.push_back(din);
                    if (fr.size() == 8) begin
                        for (int k = 0; k < 8; k++) exp_q[k] = fr[k];
                        fr.delete();
                        exp_fd = 1'b1;
                    end
                end
            end
            exp_slot = fr.size();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 8; k++) chk($sformatf("q%0d", k), int'(dq[k]), int'(exp_q[k]));
        chk("frame_done", int'(frame_done), int'(exp_fd));
        chk("slot", int'(slot), exp_slot);
`ifdef TDM_DEMUX_ERR_EN
        chk("err", int'(err), int'(exp_err));
`endif
    end

    task automatic cyc(input logic v, input logic s, input int d);
        valid = v;
        sof   = s;
        din   = d[N-1:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_slot", int'(slot), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_q0", int'(dq[0]), 0);
        chk("rst_q7", int'(dq[7]), 0);
        reset = 1'b0;
        cyc(0, 0, 0);

        // Single gapless frame 0..7
        for (int k = 0; k < 8; k++) begin
            cyc(1, k == 0, k);
            chk("f1_slot", int'(slot), (k + 1) % 8);
        end
        chk("f1_fd", int'(frame_done), 1);
        for (int k = 0; k < 8; k++) chk("f1_q", int'(dq[k]), k);
        cyc(0, 0, 0);
        chk("f1_fd_off", int'(frame_done), 0);

        // Back-to-back frames 0..7 then 7..0
        for (int k = 0; k < 16; k++) begin
            cyc(1, (k % 8) == 0, (k < 8) ? k : 15 - k);
            if (k == 7) chk("b2b_fd1", int'(frame_done), 1);
            if (k == 8) chk("b2b_fd_gap", int'(frame_done), 0);
        end
        chk("b2b_fd2", int'(frame_done), 1);
        for (int k = 0; k < 8; k++) chk("b2b_q", int'(dq[k]), 7 - k);
        cyc(0, 0, 0);

        // Frame with two idle cycles between words
        for (int k = 0; k < 8; k++) begin
            cyc(1, k == 0, k);
            if (k < 7) begin
                repeat (2) begin
                    cyc(0, 0, 0);
                    chk("gap_slot", int'(slot), k + 1);
                end
            end
        end
        chk("gap_fd", int'(frame_done), 1);
        for (int k = 0; k < 8; k++) chk("gap_q", int'(dq[k]), k);
        cyc(0, 0, 0);

        // Short frame of 5 words, then a full frame of 6s
        for (int k = 0; k < 5; k++) cyc(1, k == 0, 2);
        chk("short_slot", int'(slot), 5);
        chk("short_q3", int'(dq[3]), 3);
        cyc(1, 1, 6);
        chk("restart_slot", int'(slot), 1);
`ifdef TDM_DEMUX_ERR_EN
        chk("restart_err", int'(err), 1);
`endif
        for (int k = 1; k < 8; k++) cyc(1, 0, 6);
        chk("short_fd", int'(frame_done), 1);
        for (int k = 0; k < 8; k++) chk("short_q", int'(dq[k]), 6);
        cyc(0, 0, 0);

        // Stray word in IDLE
        cyc(1, 0, 5);
        chk("stray_slot", int'(slot), 0);
        chk("stray_q2", int'(dq[2]), 6);
        chk("stray_fd", int'(frame_done), 0);
`ifdef TDM_DEMUX_ERR_EN
        chk("stray_err", int'(err), 1);
`endif
        cyc(0, 0, 0);

        // Asynchronous reset mid-frame, then a full frame 1..7,0
        for (int k = 0; k < 4; k++) cyc(1, k == 0, 1);
        valid = 1'b0;
        sof   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_slot", int'(slot), 0);
        chk("arst_fd", int'(frame_done), 0);
        chk("arst_q0", int'(dq[0]), 0);
        chk("arst_q7", int'(dq[7]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(1, k == 0, (k + 1) % 8);
        chk("post_fd", int'(frame_done), 1);
        chk("post_q0", int'(dq[0]), 1);
        chk("post_q3", int'(dq[3]), 4);
        chk("post_q7", int'(dq[7]), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
